alu_program_sequencer: RTL and testbench



---
 rtl/alu_program_sequencer.sv | 176 +++++++++++++++++
 tb/tb_alu_program_sequencer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_program_sequencer.sv
// Fetch/execute controller that walks a 16-entry program through an external
// combinational 8-bit ALU, with a 4x8 register file, Z/C flags and a busy watchdog.
module alu_program_sequencer #(
    parameter int DATA_W     = 8,
    parameter int PC_W       = 4,
    parameter int MAX_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              prog_we,
    input  logic [PC_W-1:0]   prog_addr,
    input  logic [15:0]       prog_data,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        opcode,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              carry_in,
    input  logic [1:0]        dbg_sel,
    output logic [DATA_W-1:0] dbg_data,
    output logic [PC_W-1:0]   pc,
    output logic              busy,
    output logic              done,
    output logic              fault
);
    localparam int CNT_W = $clog2(MAX_CYCLES + 1);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_WB, S_HALTED} state_e;

    state_e                  state_q, state_d;
    logic [15:0]             mem_q [2**PC_W];
    logic [PC_W-1:0]         pc_q, pc_d;
    logic [15:0]             instr_q, instr_d;
    logic [3:0][DATA_W-1:0]  regs_q, regs_d;
    logic                    z_q, z_d, c_q, c_d, fault_q, fault_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0]       a_q, a_d, b_q, b_d;
    logic [2:0]              op_q, op_d;
    logic                    wdog;

    logic [1:0] cls, rd, ra, rb;
    logic [2:0] op;
    assign cls = instr_q[15:14];
    assign op  = instr_q[13:11];
    assign rd  = instr_q[10:9];
    assign ra  = instr_q[8:7];
    assign rb  = instr_q[6:5];

    // Watchdog fires on the busy cycle that brings the count to MAX_CYCLES.
    assign wdog = busy && (cnt_q == CNT_W'(MAX_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_HALTED: if (start) state_d = S_FETCH;
            S_FETCH:          state_d = S_EXEC;
            S_EXEC: begin
                case (cls)
                    2'b00:   state_d = S_WB;
                    2'b11:   state_d = S_HALTED;
                    default: state_d = S_FETCH;
                endcase
            end
            S_WB:             state_d = S_FETCH;
            default:          state_d = S_IDLE;
        endcase
        if (wdog) state_d = S_HALTED;
    end

    always_comb begin
        busy     = (state_q == S_FETCH) || (state_q == S_EXEC) || (state_q == S_WB);
        done     = (state_q == S_HALTED);
        fault    = fault_q;
        pc       = pc_q;
        dbg_data = regs_q[dbg_sel];
        alu_a    = a_q;
        alu_b    = b_q;
        opcode   = op_q;
        if (state_q == S_EXEC && cls == 2'b00) begin
            alu_a  = regs_q[ra];
            alu_b  = regs_q[rb];
            opcode = op;
        end
    end

    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        regs_d  = regs_q;
        z_d     = z_q;
        c_d     = c_q;
        fault_d = fault_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        case (state_q)
            S_IDLE, S_HALTED: begin
                if (start) begin
                    pc_d    = '0;
                    cnt_d   = '0;
                    fault_d = 1'b0;
                end
            end
            S_FETCH: instr_d = mem_q[pc_q];
            S_EXEC: begin
                case (cls)
                    2'b00: begin
                        a_d  = regs_q[ra];
                        b_d  = regs_q[rb];
                        op_d = op;
                    end
                    2'b01: begin
                        regs_d[rd] = instr_q[DATA_W-1:0];
                        pc_d       = pc_q + 1'b1;
                    end
                    2'b10:   pc_d = z_q ? pc_q + 1'b1 : instr_q[PC_W-1:0];
                    default: ;
                endcase
            end
            S_WB: begin
                regs_d[rd] = alu_out;
                z_d        = (alu_out == '0);
                c_d        = carry_in;
                pc_d       = pc_q + 1'b1;
            end
            default: ;
        endcase
        if (busy) cnt_d = cnt_q + 1'b1;
        // A watchdog stop abandons whatever the current instruction would commit.
        if (wdog) begin
            fault_d = 1'b1;
            pc_d    = pc_q;
            regs_d  = regs_q;
            z_d     = z_q;
            c_d     = c_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= '0;
            instr_q <= '0;
            regs_q  <= '0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
            fault_q <= 1'b0;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            regs_q  <= regs_d;
            z_q     <= z_d;
            c_q     <= c_d;
            fault_q <= fault_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
        end
    end

    // Program store is deliberately not reset; loads are accepted only when idle or halted.
    always_ff @(posedge clk) begin
        if (prog_we && (state_q == S_IDLE || state_q == S_HALTED))
            mem_q[prog_addr] <= prog_data;
    end
endmodule

// File: tb/tb_alu_program_sequencer.sv
// Directed bench for alu_program_sequencer: table of whole-program runs plus
// hand sequences for reset mid-run, writes/start while busy, and watchdog restart.
module tb_alu_program_sequencer;
    logic       clk, reset, start, prog_we;
    logic [3:0] prog_addr;
    logic [15:0] prog_data;
    logic [7:0] alu_a, alu_b, alu_out, dbg_data;
    logic [2:0] opcode;
    logic       carry_in;
    logic [1:0] dbg_sel;
    logic [3:0] pc;
    logic       busy, done, fault;

    int checks = 0;
    int fails  = 0;

    alu_program_sequencer #(.DATA_W(8), .PC_W(4), .MAX_CYCLES(255)) dut (
        .clk(clk), .reset(reset), .start(start), .prog_we(prog_we),
        .prog_addr(prog_addr), .prog_data(prog_data), .alu_a(alu_a), .alu_b(alu_b),
        .opcode(opcode), .alu_out(alu_out), .carry_in(carry_in), .dbg_sel(dbg_sel),
        .dbg_data(dbg_data), .pc(pc), .busy(busy), .done(done), .fault(fault)
    );

    always #5 clk = ~clk;

    // Reference ALU: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 MUL, 6 DIV, 7 pass A
    always_comb begin
        logic [15:0] w;
        w        = '0;
        carry_in = 1'b0;
        case (opcode)
            3'd0: begin w = {8'h0, alu_a} + {8'h0, alu_b}; carry_in = w[8]; end
            3'd1: begin w = {8'h0, alu_a - alu_b}; carry_in = (alu_a < alu_b); end
            3'd2: w = {8'h0, alu_a & alu_b};
            3'd3: w = {8'h0, alu_a | alu_b};
            3'd4: w = {8'h0, alu_a ^ alu_b};
            3'd5: begin w = {8'h0, alu_a} * {8'h0, alu_b}; carry_in = |w[15:8]; end
            3'd6: begin
                if (alu_b == 8'h0) begin w = '0; carry_in = 1'b1; end
                else w = {8'h0, alu_a / alu_b};
            end
            default: w = {8'h0, alu_a};
        endcase
        alu_out = w[7:0];
    end

    localparam logic [15:0] HALT = 16'hC000;
    function automatic logic [15:0] f_alu(input logic [2:0] o, input logic [1:0] d, a, b);
        return {2'b00, o, d, a, b, 5'b0};
    endfunction
    function automatic logic [15:0] f_ldi(input logic [1:0] d, input logic [7:0] imm);
        return {2'b01, 3'b0, d, 1'b0, imm};
    endfunction
    function automatic logic [15:0] f_jnz(input logic [3:0] t);
        return {2'b10, 10'b0, t};
    endfunction

    typedef struct {
        string               name;
        logic [15:0][15:0]   prog;
        int                  busy_n;
        logic [3:0][7:0]     r;
        logic                flt;
        logic [3:0]          pc_e;
    } vec_t;
    vec_t vec [9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic load(input logic [15:0][15:0] p);
        for (int a = 0; a < 16; a++) begin
            @(negedge clk);
            prog_we = 1'b1; prog_addr = 4'(a); prog_data = p[a];
        end
        @(negedge clk);
        prog_we = 1'b0;
    endtask

    task automatic do_reset;
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
    endtask

    task automatic pulse_start;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic continue_run(input int n0, output int n);
        int guard = 0;
        n = n0;
        while (!done && guard < 600) begin
            @(negedge clk);
            guard++;
            if (busy) n++;
        end
        if (!done) begin
            checks++; fails++;
            $display("FAIL run_timeout: got done=0 expected done=1");
        end
    endtask

    task automatic run(output int n);
        pulse_start();
        continue_run(busy ? 1 : 0, n);
    endtask

    task automatic chk_reg(input string nm, input logic [1:0] s, input logic [7:0] exp);
        dbg_sel = s; #1;
        chk($sformatf("%s_R%0d", nm, s), dbg_data, exp);
    endtask

    task automatic set_vec(input int v, input string nm, input int bn,
                           input logic [3:0][7:0] r, input logic f, input logic [3:0] p);
        vec[v].name = nm; vec[v].busy_n = bn; vec[v].r = r; vec[v].flt = f; vec[v].pc_e = p;
        for (int a = 0; a < 16; a++) vec[v].prog[a] = HALT;
    endtask

    initial begin
        int n;
        clk = 0; reset = 1; start = 0; prog_we = 0; prog_addr = 0; prog_data = 0; dbg_sel = 0;

        // r is {R3,R2,R1,R0}
        set_vec(0, "add", 9, {8'h00, 8'h08, 8'h03, 8'h05}, 1'b0, 4'd3);
        vec[0].prog[0] = f_ldi(0, 5); vec[0].prog[1] = f_ldi(1, 3); vec[0].prog[2] = f_alu(0, 2, 0, 1);
        set_vec(1, "add_z0", 13, {8'h77, 8'h08, 8'h03, 8'h05}, 1'b0, 4'd6);
        vec[1].prog[0] = f_ldi(0, 5); vec[1].prog[1] = f_ldi(1, 3); vec[1].prog[2] = f_alu(0, 2, 0, 1);
        vec[1].prog[3] = f_jnz(5); vec[1].prog[5] = f_ldi(3, 8'h77);
        set_vec(2, "countdown", 2 + 2 + 3 * (3 + 2) + 2, {8'h00, 8'h00, 8'h01, 8'h00}, 1'b0, 4'd4);
        vec[2].prog[0] = f_ldi(0, 3); vec[2].prog[1] = f_ldi(1, 1); vec[2].prog[2] = f_alu(1, 0, 0, 1);
        vec[2].prog[3] = f_jnz(2);
        set_vec(3, "div0", 15, {8'h11, 8'h00, 8'h00, 8'h07}, 1'b0, 4'd6);
        vec[3].prog[0] = f_ldi(2, 8'hFF); vec[3].prog[1] = f_ldi(0, 7); vec[3].prog[2] = f_ldi(1, 0);
        vec[3].prog[3] = f_alu(6, 2, 0, 1); vec[3].prog[4] = f_jnz(7); vec[3].prog[5] = f_ldi(3, 8'h11);
        set_vec(4, "div2", 11, {8'h00, 8'h03, 8'h02, 8'h07}, 1'b0, 4'd5);
        vec[4].prog[0] = f_ldi(0, 7); vec[4].prog[1] = f_ldi(1, 2); vec[4].prog[2] = f_alu(6, 2, 0, 1);
        vec[4].prog[3] = f_jnz(5);
        set_vec(5, "mul_trunc", 9, {8'h30, 8'h00, 8'h10, 8'h13}, 1'b0, 4'd3);
        vec[5].prog[0] = f_ldi(0, 8'h13); vec[5].prog[1] = f_ldi(1, 8'h10); vec[5].prog[2] = f_alu(5, 3, 0, 1);
        set_vec(6, "rd_eq_ra", 12, {8'h00, 8'h00, 8'h12, 8'h00}, 1'b0, 4'd4);
        vec[6].prog[0] = f_ldi(0, 8'h44); vec[6].prog[1] = f_ldi(1, 9); vec[6].prog[2] = f_alu(0, 1, 1, 1);
        vec[6].prog[3] = f_alu(4, 0, 1, 1);
        set_vec(7, "pc_wrap", 11, {8'h5A, 8'h00, 8'h00, 8'h00}, 1'b0, 4'd1);
        vec[7].prog[0] = f_jnz(14); vec[7].prog[14] = f_alu(1, 1, 1, 1); vec[7].prog[15] = f_ldi(3, 8'h5A);
        set_vec(8, "watchdog", 255, {8'h00, 8'h00, 8'h00, 8'h00}, 1'b1, 4'd0);
        vec[8].prog[0] = f_jnz(0);

        // Reset state
        do_reset();
        chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_fault", fault, 0);
        chk("rst_pc", pc, 0); chk("rst_alu_a", alu_a, 0); chk("rst_alu_b", alu_b, 0);
        chk("rst_opcode", opcode, 0);
        for (int k = 0; k < 4; k++) chk_reg("rst", 2'(k), 8'h00);

        // Table of whole-program runs, each from reset
        for (int v = 0; v < 9; v++) begin
            do_reset();
            load(vec[v].prog);
            run(n);
            chk({vec[v].name, "_busy"}, n, vec[v].busy_n);
            chk({vec[v].name, "_done"}, done, 1);
            chk({vec[v].name, "_fault"}, fault, vec[v].flt);
            chk({vec[v].name, "_pc"}, pc, vec[v].pc_e);
            for (int k = 0; k < 4; k++) chk_reg(vec[v].name, 2'(k), vec[v].r[k]);
        end

        // Restart after watchdog: fault/done clear, operands held through WB
        load(vec[0].prog);
        pulse_start();
        chk("wd_restart_fault", fault, 0); chk("wd_restart_done", done, 0);
        repeat (6) @(negedge clk);
        chk("wb_alu_a", alu_a, 8'h05); chk("wb_alu_b", alu_b, 8'h03); chk("wb_opcode", opcode, 0);
        continue_run(7, n);
        chk("wd_restart_busy", n, 9); chk("wd_restart_fault_end", fault, 0);
        chk_reg("wd_restart", 2'd2, 8'h08);

        // Reset in the middle of the countdown loop
        do_reset();
        load(vec[2].prog);
        pulse_start();
        repeat (7) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_busy", busy, 0); chk("midrst_done", done, 0); chk("midrst_pc", pc, 0);
        for (int k = 0; k < 4; k++) chk_reg("midrst", 2'(k), 8'h00);
        reset = 1'b0;
        run(n);
        chk("midrst_rerun_busy", n, 21); chk_reg("midrst_rerun", 2'd0, 8'h00);
        chk_reg("midrst_rerun", 2'd1, 8'h01);

        // start and prog_we while busy are both ignored
        pulse_start();
        repeat (4) @(negedge clk);
        start = 1'b1; prog_we = 1'b1; prog_addr = 4'd0; prog_data = f_ldi(0, 9);
        @(negedge clk);
        start = 1'b0; prog_we = 1'b0;
        chk("busy_start_pc", pc, 4'd2); chk("busy_start_busy", busy, 1);
        continue_run(6, n);
        chk("busy_start_total", n, 21); chk_reg("busy_start", 2'd0, 8'h00);
        run(n);
        chk("busy_we_rerun", n, 21);

        // prog_we in HALTED takes effect
        @(negedge clk);
        prog_we = 1'b1; prog_addr = 4'd0; prog_data = f_ldi(0, 2);
        @(negedge clk);
        prog_we = 1'b0;
        run(n);
        chk("halted_we_busy", n, 2 + 2 + 2 * 5 + 2); chk_reg("halted_we", 2'd0, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
